// File: rtl/pixel_scan_feeder.sv
// rtl/pixel_scan_feeder.sv - raster-order pixel fetcher paced by a run timer or a step button
// Optional feature macro: PIXEL_FEEDER_DEBOUNCE_EN (stable-low debounce on step_n)
module pixel_scan_feeder #(
   parameter int TICK_CYCLES     = 50_000_000,
   parameter int IMG_W           = 160,
   parameter int IMG_H           = 120,
   parameter int ADDR_W          = 15,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic              clk_50mhz,
   input  logic              rst,
   input  logic              run,
   input  logic              step_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [7:0]        mem_data,
   output logic [7:0]        pixel_data_out,
   output logic              new_data_tick,
   output logic [7:0]        pixel_x,
   output logic [7:0]        pixel_y,
   output logic              frame_done
);

   localparam int               CNT_W    = $clog2(TICK_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_CYCLES - 2);
   localparam logic [7:0]       X_LAST   = 8'(IMG_W - 1);
   localparam logic [7:0]       Y_LAST   = 8'(IMG_H - 1);

   if (TICK_CYCLES < 4 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
      $error("pixel_scan_feeder: TICK_CYCLES must be >= 4 and DEBOUNCE_CYCLES >= 1");
   end

   typedef enum logic [1:0] {IDLE, READ, CAPTURE} state_t;

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  period_cnt;
   logic [7:0]        scan_x;
   logic [7:0]        scan_y;
   logic [ADDR_W-1:0] scan_addr;
   logic              sync_1;
   logic              sync_2;
   logic [1:0]        warm;
   logic              armed;
   logic              press;
   logic              auto_due;
   logic              last_pixel;

   // two-flop synchronizer for the raw button, preset to the released level
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
      end else begin
         sync_1 <= step_n;
         sync_2 <= sync_1;
      end
   end

   // arm press detection only after the synchronizer has shown a real released level,
   // so a button held through reset cannot masquerade as a press
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         warm  <= 2'b00;
         armed <= 1'b0;
      end else begin
         warm  <= {warm[0], 1'b1};
         armed <= armed | (warm[1] & sync_2);
      end
   end

`ifdef PIXEL_FEEDER_DEBOUNCE_EN
   localparam int               DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_FULL = DEB_W'(DEBOUNCE_CYCLES);
   localparam logic [DEB_W-1:0] DEB_HIT  = DEB_W'(DEBOUNCE_CYCLES - 1);

   logic [DEB_W-1:0] low_cnt;

   // count consecutive low cycles, saturating so one low period yields one press
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         low_cnt <= '0;
      end else if (sync_2) begin
         low_cnt <= '0;
      end else if (low_cnt != DEB_FULL) begin
         low_cnt <= low_cnt + DEB_W'(1);
      end
   end

   assign press = armed && !sync_2 && (low_cnt == DEB_HIT);
`else
   logic sync_prev;

   // previous synchronized level for falling-edge detection
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         sync_prev <= 1'b1;
      end else begin
         sync_prev <= sync_2;
      end
   end

   assign press = armed && sync_prev && !sync_2;
`endif

   // free-running period counter while run is high, parked at zero otherwise
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         period_cnt <= '0;
      end else if (!run || period_cnt == CNT_LAST) begin
         period_cnt <= '0;
      end else begin
         period_cnt <= period_cnt + CNT_W'(1);
      end
   end

   // READ is entered on the same edge the counter reaches its last value
   assign auto_due   = run && (period_cnt == CNT_PRE);
   assign last_pixel = (scan_x == X_LAST) && (scan_y == Y_LAST);
   assign mem_addr   = scan_addr;

   // fetch state register
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // fetch sequencing; presses outside IDLE or while running are dropped
   always_comb begin
      state_next = state;
      mem_rd_en  = 1'b0;
      case (state)
         IDLE: begin
            if (auto_due || (!run && press)) begin
               state_next = READ;
            end
         end
         READ: begin
            mem_rd_en  = 1'b1;
            state_next = CAPTURE;
         end
         CAPTURE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // capture the returned pixel, publish its coordinates, then advance the raster position
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         scan_x         <= 8'd0;
         scan_y         <= 8'd0;
         scan_addr      <= '0;
         pixel_data_out <= 8'd0;
         pixel_x        <= 8'd0;
         pixel_y        <= 8'd0;
         new_data_tick  <= 1'b0;
         frame_done     <= 1'b0;
      end else begin
         new_data_tick <= (state == CAPTURE);
         frame_done    <= (state == CAPTURE) && last_pixel;
         if (state == CAPTURE) begin
            pixel_data_out <= mem_data;
            pixel_x        <= scan_x;
            pixel_y        <= scan_y;
            if (last_pixel) begin
               scan_x    <= 8'd0;
               scan_y    <= 8'd0;
               scan_addr <= '0;
            end else if (scan_x == X_LAST) begin
               scan_x    <= 8'd0;
               scan_y    <= scan_y + 8'd1;
               scan_addr <= scan_addr + ADDR_W'(1);
            end else begin
               scan_x    <= scan_x + 8'd1;
               scan_addr <= scan_addr + ADDR_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_pixel_scan_feeder.sv
// tb/tb_pixel_scan_feeder.sv - self-checking bench for pixel_scan_feeder
module tb_pixel_scan_feeder;

   localparam int TICK = 10;
   localparam int W    = 4;
   localparam int H    = 2;
   localparam int AW   = 4;
   localparam int DEB  = 5;
   localparam int NPIX = W * H;
`ifdef PIXEL_FEEDER_DEBOUNCE_EN
   localparam int STEP_LAT = DEB + 4;
   localparam int MIN_LOW  = DEB;
`else
   localparam int STEP_LAT = 5;
   localparam int MIN_LOW  = 1;
`endif

   logic          clk_50mhz = 1'b0;
   logic          rst       = 1'b0;
   logic          run       = 1'b0;
   logic          step_n    = 1'b1;
   logic [AW-1:0] mem_addr;
   logic          mem_rd_en;
   logic [7:0]    mem_data  = 8'hEE;
   logic [7:0]    pixel_data_out;
   logic          new_data_tick;
   logic [7:0]    pixel_x;
   logic [7:0]    pixel_y;
   logic          frame_done;

   pixel_scan_feeder #(
      .TICK_CYCLES     (TICK),
      .IMG_W           (W),
      .IMG_H           (H),
      .ADDR_W          (AW),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk_50mhz      (clk_50mhz),
      .rst            (rst),
      .run            (run),
      .step_n         (step_n),
      .mem_addr       (mem_addr),
      .mem_rd_en      (mem_rd_en),
      .mem_data       (mem_data),
      .pixel_data_out (pixel_data_out),
      .new_data_tick  (new_data_tick),
      .pixel_x        (pixel_x),
      .pixel_y        (pixel_y),
      .frame_done     (frame_done)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   // memory: data valid only in the cycle after the read strobe
   always @(posedge clk_50mhz) begin
      mem_data <= mem_rd_en ? (8'(mem_addr) + 8'h10) : 8'hEE;
   end

   int cyc = 0;
   always @(posedge clk_50mhz) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state: next pixel index of the raster, last published data
   int ticks_seen   = 0;
   int rd_seen      = 0;
   int exp_idx      = 0;
   int held         = 0;
   int prev_tick    = -1;
   int seg_first    = -1;
   int last_rd_addr = -1;
   bit spacing_on   = 1'b0;

   typedef struct {
      int low_len;
      int exp_ticks;
      int exp_lat;
   } step_vec_t;

   step_vec_t vecs[$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_mem_addr"}, int'(mem_addr), 0);
      check({tag, "_mem_rd_en"}, int'(mem_rd_en), 0);
      check({tag, "_pixel_data"}, int'(pixel_data_out), 0);
      check({tag, "_tick"}, int'(new_data_tick), 0);
      check({tag, "_pixel_x"}, int'(pixel_x), 0);
      check({tag, "_pixel_y"}, int'(pixel_y), 0);
      check({tag, "_frame_done"}, int'(frame_done), 0);
   endtask

   task automatic monitor();
      if (rst) begin
         exp_idx   = 0;
         held      = 0;
         prev_tick = -1;
         check_zero("rst_hold");
         return;
      end
      if (!spacing_on) prev_tick = -1;
      if (mem_rd_en) begin
         rd_seen++;
         last_rd_addr = int'(mem_addr);
         check("rd_addr", int'(mem_addr), exp_idx);
      end
      if (new_data_tick) begin
         ticks_seen++;
         if (seg_first < 0) seg_first = cyc;
         check("tick_x", int'(pixel_x), exp_idx % W);
         check("tick_y", int'(pixel_y), exp_idx / W);
         check("tick_data", int'(pixel_data_out), (exp_idx + 16) % 256);
         check("tick_frame_done", int'(frame_done), (exp_idx == NPIX - 1) ? 1 : 0);
         if (prev_tick >= 0) check("tick_spacing", cyc - prev_tick, TICK);
         prev_tick = spacing_on ? cyc : -1;
         held      = (exp_idx + 16) % 256;
         exp_idx   = (exp_idx + 1) % NPIX;
      end else begin
         check("frame_done_idle", int'(frame_done), 0);
         check("pixel_hold", int'(pixel_data_out), held);
      end
   endtask

   // one clock: sample mid-cycle, then return just after the next rising edge
   task automatic cycle();
      @(negedge clk_50mhz);
      monitor();
      @(posedge clk_50mhz);
      #1;
   endtask

   task automatic wait_ticks(input int target, input int budget, input string name);
      int n = 0;
      while (ticks_seen < target && n < budget) begin
         cycle();
         n++;
      end
      check(name, ticks_seen, target);
   endtask

   task automatic wait_rd(input int target, input int budget, input string name);
      int n = 0;
      while (rd_seen < target && n < budget) begin
         cycle();
         n++;
      end
      check(name, rd_seen, target);
   endtask

   task automatic run_segment(input int m, input string tag);
      int r;
      int t0;
      t0         = ticks_seen;
      seg_first  = -1;
      spacing_on = 1'b1;
      r          = cyc;
      run        = 1'b1;
      wait_ticks(t0 + m, m * TICK + 20, {tag, "_ticks"});
      run        = 1'b0;
      spacing_on = 1'b0;
      check({tag, "_first_lat"}, seg_first - r, TICK + 1);
      repeat (15) cycle();
      check({tag, "_no_extra"}, ticks_seen - t0, m);
   endtask

   task automatic step_press(input int len, input int exp_ticks, input int exp_lat, input string tag);
      int n;
      int t0;
      int r0;
      t0        = ticks_seen;
      r0        = rd_seen;
      seg_first = -1;
      n         = cyc;
      step_n    = 1'b0;
      repeat (len) cycle();
      step_n = 1'b1;
      repeat (20) cycle();
      check({tag, "_ticks"}, ticks_seen - t0, exp_ticks);
      check({tag, "_reads"}, rd_seen - r0, exp_ticks);
      if (exp_ticks > 0) check({tag, "_lat"}, seg_first - n, exp_lat);
   endtask

   initial begin
      int t0;
      int r0;
      int len;
      int m;

`ifdef PIXEL_FEEDER_DEBOUNCE_EN
      vecs.push_back('{3, 0, -1});
      vecs.push_back('{6, 1, STEP_LAT});
      vecs.push_back('{1, 0, -1});
      vecs.push_back('{5, 1, STEP_LAT});
      vecs.push_back('{10, 1, STEP_LAT});
`else
      vecs.push_back('{1, 1, STEP_LAT});
      vecs.push_back('{2, 1, STEP_LAT});
      vecs.push_back('{4, 1, STEP_LAT});
      vecs.push_back('{8, 1, STEP_LAT});
`endif

      // reset is asynchronous: outputs must clear before any clock edge
      #2 rst = 1'b1;
      #1 check_zero("por");
      repeat (3) cycle();
      rst = 1'b0;
      repeat (6) cycle();

      // free-running auto-advance through one full frame and the wrap
      run_segment(9, "run9");
      check("run9_frame_wrap_idx", exp_idx, 1);

      // presses while running, one landing in a fetch, must not disturb pacing
      t0         = ticks_seen;
      seg_first  = -1;
      spacing_on = 1'b1;
      run        = 1'b1;
      wait_ticks(t0 + 1, 30, "runstep_first");
      step_n = 1'b0;
      repeat (8) cycle();
      step_n = 1'b1;
      r0 = rd_seen;
      wait_rd(r0 + 1, 20, "runstep_rd");
      step_n = 1'b0;
      repeat (6) cycle();
      step_n = 1'b1;
      wait_ticks(t0 + 4, 60, "runstep_ticks");
      run        = 1'b0;
      spacing_on = 1'b0;
      repeat (15) cycle();
      check("runstep_no_extra", ticks_seen - t0, 4);

`ifndef PIXEL_FEEDER_DEBOUNCE_EN
      // second press recognized mid-fetch is discarded
      t0     = ticks_seen;
      step_n = 1'b0;
      cycle();
      step_n = 1'b1;
      cycle();
      step_n = 1'b0;
      cycle();
      step_n = 1'b1;
      repeat (20) cycle();
      check("dbl_press_ticks", ticks_seen - t0, 1);
`endif

      // run falling during a fetch still completes that fetch
      t0  = ticks_seen;
      r0  = rd_seen;
      run = 1'b1;
      wait_rd(r0 + 1, 20, "runfall_rd");
      run = 1'b0;
      repeat (30) cycle();
      check("runfall_ticks", ticks_seen - t0, 1);

      // reset during CAPTURE aborts the fetch; next fetch restarts at address 0
      r0  = rd_seen;
      run = 1'b1;
      wait_rd(r0 + 1, 20, "caprst_rd");
      t0  = ticks_seen;
      rst = 1'b1;
      #1 check_zero("caprst");
      run = 1'b0;
      repeat (3) cycle();
      rst = 1'b0;
      repeat (20) cycle();
      check("caprst_no_tick", ticks_seen - t0, 0);
      r0 = rd_seen;
      step_press(MIN_LOW + 2, 1, STEP_LAT, "caprst_step");
      check("caprst_addr0", last_rd_addr, 0);
      check("caprst_data", held, 8'h10);

      // button held through reset produces no press, nor does its release
      t0     = ticks_seen;
      rst    = 1'b1;
      step_n = 1'b0;
      repeat (3) cycle();
      rst = 1'b0;
      repeat (15) cycle();
      check("held_rst_no_press", ticks_seen - t0, 0);
      step_n = 1'b1;
      repeat (10) cycle();
      check("held_rst_release", ticks_seen - t0, 0);

      // table of step pulses
      for (int i = 0; i < vecs.size(); i++) begin
         step_press(vecs[i].low_len, vecs[i].exp_ticks, vecs[i].exp_lat, $sformatf("vec%0d", i));
      end

      // randomized mix of run bursts and step presses against the raster model
      for (int k = 0; k < 12; k++) begin
         if ($urandom_range(0, 1) == 1) begin
            m = $urandom_range(1, 4);
            run_segment(m, $sformatf("rnd%0d_run", k));
         end else begin
            len = $urandom_range(MIN_LOW, MIN_LOW + 6);
            step_press(len, 1, STEP_LAT, $sformatf("rnd%0d_step", k));
         end
         repeat ($urandom_range(2, 10)) cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pixel_scan_feeder.md
PIXEL_SCAN_FEEDER -- requirements
Module: pixel_scan_feeder

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 50_000_000, auto-advance period in clk_50mhz cycles (min 4).
REQ-002 SHALL have parameter IMG_W, default 160, image width in pixels.
REQ-003 SHALL have parameter IMG_H, default 120, image height in pixels.
REQ-004 SHALL have parameter ADDR_W, default 15, address width (2^ADDR_W >= IMG_W*IMG_H).
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, stable-low time for the step button (used only with the REQ-031 macro).
REQ-006 SHALL have port clk_50mhz  in  1  system clock, 50 MHz.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port run  in  1  level; 1 = auto-advance one pixel per TICK_CYCLES.
REQ-009 SHALL have port step_n  in  1  raw push-button, active-low, asynchronous to clk_50mhz.
REQ-010 SHALL have port mem_addr  out  ADDR_W  pixel memory read address.
REQ-011 SHALL have port mem_rd_en  out  1  memory read strobe.
REQ-012 SHALL have port mem_data  in  8  memory read data, valid exactly 1 cycle after the mem_rd_en cycle.
REQ-013 SHALL have port pixel_data_out  out  8  last fetched pixel, held stable between ticks.
REQ-014 SHALL have port new_data_tick  out  1  one-cycle pulse; pixel_data_out is new in this cycle.
REQ-015 SHALL have port pixel_x  out  8  column of the pixel in pixel_data_out.
REQ-016 SHALL have port pixel_y  out  8  row of the pixel in pixel_data_out.
REQ-017 SHALL have port frame_done  out  1  one-cycle pulse, coincident with the tick of the last pixel (IMG_W-1, IMG_H-1).

Function
REQ-018 SHALL implement the FSM IDLE -> READ -> CAPTURE -> IDLE, with READ and CAPTURE each lasting exactly one cycle.
REQ-019 SHALL, with run=1, count period cycles 0..TICK_CYCLES-1 free-running and leave IDLE for READ in the cycle the count reaches TICK_CYCLES-1.
REQ-020 SHALL hold the period counter at 0 while run=0; after a run rise, the first READ occurs TICK_CYCLES-1 cycles later.
REQ-021 SHALL, with run=0 in IDLE, enter READ on the cycle after a recognized step press; presses while run=1 or in READ/CAPTURE are discarded, not queued.
REQ-022 SHALL drive mem_rd_en=1 only in READ, with mem_addr = scan address (y*IMG_W+x), stable from READ through CAPTURE.
REQ-023 SHALL load pixel_data_out from mem_data at the end of CAPTURE; new_data_tick, pixel_x/pixel_y update and frame_done assert in the following cycle.
REQ-024 SHALL give a latency of 2 cycles from READ entry to new_data_tick; with run=1, the tick spacing is exactly TICK_CYCLES.
REQ-025 SHALL advance the scan address after CAPTURE: x+1; at x=IMG_W-1, x=0 and y+1; at (IMG_W-1, IMG_H-1), wrap to (0,0).
REQ-026 SHALL, on a run fall during READ/CAPTURE, complete the fetch and emit its tick.
REQ-027 SHALL recognize a step press as the falling edge of step_n after a two-flop synchronizer.

Reset
REQ-028 SHALL, on rst assertion, immediately force: state IDLE, counter 0, scan address (0,0), mem_addr 0, mem_rd_en 0, pixel_data_out 0, new_data_tick 0, pixel_x/pixel_y 0, frame_done 0.
REQ-029 SHALL preset synchronizer/debounce registers to released (1), so that a button held through reset produces no press.
REQ-030 SHALL abort an in-flight fetch on rst assertion mid-READ/CAPTURE without emitting a tick; after release, the first fetch is address 0.

Configuration
REQ-031 SHALL, when PIXEL_FEEDER_DEBOUNCE_EN is defined, recognize a press only after the synchronized step_n has been low for DEBOUNCE_CYCLES consecutive cycles (one press per low period); without the macro, use REQ-027 directly with no debounce logic synthesized.

Verification (TICK_CYCLES=10, IMG_W=4, IMG_H=2, mem_data = addr+8'h10, 1-cycle latency)
REQ-032 SHALL cover: rst release, run=1 -> ticks every 10 cycles; pixel_data_out 10,11,12,...; first tick 11 cycles after run rise.
REQ-033 SHALL cover: run=1 for 8 ticks -> 8th tick has pixel (3,1), data 8'h17, frame_done=1; 9th tick is (0,0), data 8'h10.
REQ-034 SHALL cover: run=0, single step_n low pulse -> exactly one mem_rd_en, tick 3 cycles after the synchronized edge, address advances by 1.
REQ-035 SHALL cover: step_n pressed while run=1, and a second press during READ -> no extra tick, tick spacing unchanged.
REQ-036 SHALL cover: rst asserted in CAPTURE -> no tick, all outputs 0 asynchronously; next fetch reads address 0.
REQ-037 SHALL cover: with PIXEL_FEEDER_DEBOUNCE_EN and DEBOUNCE_CYCLES=5, a 3-cycle low glitch -> no press; a 6-cycle low -> exactly one tick.
